// File: rtl/sspi_if.sv
// SSPI bus bundle: the SPI pins plus the register-file side of the bridge.
//   cs, sck, si : SPI inputs (chip select active-low, mode-3 clock, MOSI)
//   so          : SPI output (MISO)
//   addr, din   : register address and combinational read data
//   dout        : register write data
//   rd, we      : one-clk read / write strobes
// The slave modport is the bridge; the master modport is the SPI host and register file.
interface sspi_if;
    logic       cs;
    logic       sck;
    logic       si;
    logic       so;
    logic [6:0] addr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       rd;
    logic       we;

    modport slave (
        input  cs, sck, si, din,
        output so, addr, dout, rd, we
    );

    modport master (
        output cs, sck, si, din,
        input  so, addr, dout, rd, we
    );
endinterface

// File: rtl/sspi.sv
// SPI (mode 3) slave to register-bus bridge.
// The first byte of each cs-low transaction is a command: bits[7:1] address, bit[0] 1 = write.
// Reads pulse rd and stream din bytes out on so; writes pulse we with each received byte.
// The address auto-increments (7-bit wrap) between data bytes.
// Ports:
//   clk  : system clock, all state advances on its rising edge
//   rst  : asynchronous active-high reset
//   bus  : sspi_if slave modport (SPI pins and register-bus side)
module sspi (
    input  logic   clk,
    input  logic   rst,
    sspi_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData
    } state_e;

    // Synchronizers plus one extra history flop each for edge detection.
    logic cs_s1_q, cs_s2_q, cs_prev_q;
    logic sck_s1_q, sck_s2_q, sck_prev_q;
    logic si_s1_q, si_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            cs_prev_q  <= 1'b1;
            sck_s1_q   <= 1'b1;
            sck_s2_q   <= 1'b1;
            sck_prev_q <= 1'b1;
            si_s1_q    <= 1'b0;
            si_s2_q    <= 1'b0;
        end else begin
            cs_s1_q    <= bus.cs;
            cs_s2_q    <= cs_s1_q;
            cs_prev_q  <= cs_s2_q;
            sck_s1_q   <= bus.sck;
            sck_s2_q   <= sck_s1_q;
            sck_prev_q <= sck_s2_q;
            si_s1_q    <= bus.si;
            si_s2_q    <= si_s1_q;
        end
    end

    logic cs_fall, sck_rise, sck_fall;
    assign cs_fall  = cs_prev_q & ~cs_s2_q;
    assign sck_rise = ~sck_prev_q & sck_s2_q;
    assign sck_fall = sck_prev_q & ~sck_s2_q;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       dir_q, dir_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] dout_q, dout_d;
    logic [7:0] tx_q, tx_d;
    logic       so_q, so_d;
    logic       rd_q, rd_d;
    logic       we_q, we_d;

    // Strobes are masked by the synchronized chip select so an abort can never leak one out.
    logic rd_fire, we_fire;
    assign rd_fire = rd_q & ~cs_s2_q;
    assign we_fire = we_q & ~cs_s2_q;

    logic [7:0] byte_in;
    assign byte_in = {shift_q, si_s2_q};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        dir_d     = dir_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        tx_d      = tx_q;
        so_d      = so_q;
        rd_d      = 1'b0;
        we_d      = 1'b0;

        // Write address advances the clk after the we strobe.
        if (we_fire) begin
            addr_d = addr_q + 7'd1;
        end
        // Read data is captured on the edge that closes the rd strobe, with addr already valid.
        if (rd_fire) begin
            tx_d = bus.din;
        end

        if (cs_s2_q) begin
            // Chip select high: abort, partial byte discarded, addr/dout hold.
            state_d   = StIdle;
            bit_cnt_d = 3'd0;
            dir_d     = 1'b0;
            so_d      = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d   = StCmd;
                        bit_cnt_d = 3'd0;
                        so_d      = 1'b0;
                    end
                end
                StCmd, StData: begin
                    if (sck_fall) begin
                        if (state_q == StData && !dir_q) begin
                            so_d = tx_q[7];
                            tx_d = {tx_q[6:0], 1'b0};
                        end else begin
                            so_d = 1'b0;
                        end
                    end
                    if (sck_rise) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == StCmd) begin
                                addr_d  = byte_in[7:1];
                                dir_d   = byte_in[0];
                                state_d = StData;
                                rd_d    = ~byte_in[0];
                            end else if (dir_q) begin
                                dout_d = byte_in;
                                we_d   = 1'b1;
                            end else begin
                                addr_d = addr_q + 7'd1;
                                rd_d   = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= 3'd0;
            shift_q   <= 7'd0;
            dir_q     <= 1'b0;
            addr_q    <= 7'd0;
            dout_q    <= 8'd0;
            tx_q      <= 8'd0;
            so_q      <= 1'b0;
            rd_q      <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            dir_q     <= dir_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            tx_q      <= tx_d;
            so_q      <= so_d;
            rd_q      <= rd_d;
            we_q      <= we_d;
        end
    end

    assign bus.addr = addr_q;
    assign bus.dout = dout_q;
    assign bus.rd   = rd_fire;
    assign bus.we   = we_fire;
    // Gate with the raw pin so MISO drops as soon as the host deselects.
    assign bus.so   = so_q & ~bus.cs;

endmodule

// File: tb/tb_sspi.sv
module tb_sspi;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sspi_if bus();

    sspi dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file seen through din.
    logic [7:0] mem [128];
    assign bus.din = mem[bus.addr];

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;

    // Event word: {is_write, addr[6:0], data[7:0]}; reads carry data 0.
    logic [15:0] ev_q[$];
    logic [15:0] exp_ev[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_rx[$];
    logic [6:0]  exp_addr;

    always @(negedge clk) begin
        if (bus.rd) ev_q.push_back({1'b0, bus.addr, 8'h00});
        if (bus.we) ev_q.push_back({1'b1, bus.addr, bus.dout});
        if (bus.rd && bus.we) both_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic half_wait();
        #($urandom_range(5, 8) * 10 + $urandom_range(0, 7));
    endtask

    // One mode-3 byte: drive si on the falling edge, sample so just before the rising edge.
    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        for (int i = 7; i >= 0; i--) begin
            bus.sck = 1'b0;
            bus.si  = b[i];
            half_wait();
            r[i] = bus.so;
            bus.sck = 1'b1;
            half_wait();
        end
    endtask

    task automatic run_txn(input int gap);
        logic [7:0] r;
        bus.cs = 1'b0;
        wait_clk(4);
        foreach (tx_q[i]) begin
            spi_byte(tx_q[i], r);
            rx_q.push_back(r);
        end
        wait_clk(8);
        bus.cs = 1'b1;
        wait_clk(gap);
    endtask

    // Reference: what the host should see and which strobes the register file should get.
    task automatic model_txn();
        int a;
        int n;
        logic w;
        a = int'(tx_q[0][7:1]);
        w = tx_q[0][0];
        n = tx_q.size() - 1;
        exp_rx.push_back(8'h00);
        for (int k = 1; k <= n; k++)
            exp_rx.push_back(w ? 8'h00 : mem[(a + k - 1) % 128]);
        if (w) begin
            for (int k = 1; k <= n; k++)
                exp_ev.push_back({1'b1, 7'((a + k - 1) % 128), tx_q[k]});
        end else begin
            for (int k = 0; k <= n; k++)
                exp_ev.push_back({1'b0, 7'((a + k) % 128), 8'h00});
        end
        exp_addr = 7'((a + n) % 128);
    endtask

    task automatic clear_all();
        ev_q.delete();
        exp_ev.delete();
        rx_q.delete();
        exp_rx.delete();
        tx_q.delete();
    endtask

    task automatic test_reset();
        bus.cs  = 1'b0;
        bus.sck = 1'b1;
        bus.si  = 1'b0;
        rst     = 1'b1;
        ev_q.delete();
        for (int i = 0; i < 10; i++) begin
            bus.sck = ~bus.sck;
            bus.si  = 1'($urandom);
            #23;
        end
        @(negedge clk);
        checks++;
        if ({bus.addr, bus.dout, bus.rd, bus.we, bus.so} !== 18'd0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%h dout=%h rd=%b we=%b so=%b want all 0",
                     bus.addr, bus.dout, bus.rd, bus.we, bus.so);
        end
        bus.sck = 1'b1;
        rst = 1'b0;
        wait_clk(6);
        bus.cs = 1'b1;
        wait_clk(5);
        checks++;
        if (ev_q.size() != 0) begin
            errors++;
            $display("FAIL reset_no_strobes got %0d events want 0", ev_q.size());
        end
        checks++;
        if ({bus.addr, bus.dout, bus.so} !== 16'd0) begin
            errors++;
            $display("FAIL reset_after got addr=%h dout=%h so=%b want 0", bus.addr, bus.dout, bus.so);
        end
    endtask

    task automatic test_read();
        clear_all();
        mem[0] = 8'h5A; mem[1] = 8'hCC; mem[2] = 8'h38; mem[3] = 8'h67;
        tx_q.push_back(8'h02);
        tx_q.push_back(8'($urandom));
        tx_q.push_back(8'($urandom));
        model_txn();
        run_txn(4);
        checks++;
        if (rx_q[1] !== 8'hCC || rx_q[2] !== 8'h38) begin
            errors++;
            $display("FAIL read_fixed got %h %h want cc 38", rx_q[1], rx_q[2]);
        end
        foreach (exp_rx[i]) begin
            checks++;
            if (rx_q[i] !== exp_rx[i]) begin
                errors++;
                $display("FAIL read_rx[%0d] got %h want %h", i, rx_q[i], exp_rx[i]);
            end
        end
        checks++;
        if (ev_q.size() != exp_ev.size()) begin
            errors++;
            $display("FAIL read_ev_count got %0d want %0d", ev_q.size(), exp_ev.size());
        end else begin
            foreach (exp_ev[i]) begin
                checks++;
                if (ev_q[i] !== exp_ev[i]) begin
                    errors++;
                    $display("FAIL read_ev[%0d] got %h want %h", i, ev_q[i], exp_ev[i]);
                end
            end
        end
        checks++;
        if (bus.addr !== exp_addr) begin
            errors++;
            $display("FAIL read_addr got %h want %h", bus.addr, exp_addr);
        end
    endtask

    task automatic test_write();
        clear_all();
        tx_q.push_back(8'h05);
        tx_q.push_back(8'hC7);
        tx_q.push_back(8'h4D);
        model_txn();
        run_txn(4);
        checks++;
        if (ev_q.size() != exp_ev.size()) begin
            errors++;
            $display("FAIL write_ev_count got %0d want %0d", ev_q.size(), exp_ev.size());
        end else begin
            foreach (exp_ev[i]) begin
                checks++;
                if (ev_q[i] !== exp_ev[i]) begin
                    errors++;
                    $display("FAIL write_ev[%0d] got %h want %h", i, ev_q[i], exp_ev[i]);
                end
            end
        end
        foreach (rx_q[i]) begin
            checks++;
            if (rx_q[i] !== 8'h00) begin
                errors++;
                $display("FAIL write_so[%0d] got %h want 00", i, rx_q[i]);
            end
        end
        checks++;
        if (bus.dout !== 8'h4D || bus.addr !== exp_addr) begin
            errors++;
            $display("FAIL write_final got addr=%h dout=%h want addr=%h dout=4d",
                     bus.addr, bus.dout, exp_addr);
        end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        logic [7:0] part;
        ev_q.delete();
        part = 8'hA5;
        bus.cs = 1'b0;
        wait_clk(4);
        spi_byte(8'h0B, r);
        spi_byte(8'h96, r);
        for (int i = 7; i >= 4; i--) begin
            bus.sck = 1'b0;
            bus.si  = part[i];
            half_wait();
            bus.sck = 1'b1;
            half_wait();
        end
        bus.cs = 1'b1;
        wait_clk(6);
        for (int i = 0; i < 8; i++) begin
            bus.sck = 1'b0;
            bus.si  = 1'($urandom);
            half_wait();
            checks++;
            if (bus.so !== 1'b0) begin
                errors++;
                $display("FAIL abort_so_cs_high got %b want 0", bus.so);
            end
            bus.sck = 1'b1;
            half_wait();
        end
        wait_clk(6);
        checks++;
        if (ev_q.size() != 1 || ev_q[0] !== {1'b1, 7'd5, 8'h96}) begin
            errors++;
            $display("FAIL abort_events got count=%0d first=%h want 1 event %h",
                     ev_q.size(), (ev_q.size() > 0) ? ev_q[0] : 16'h0, {1'b1, 7'd5, 8'h96});
        end
        checks++;
        if (bus.addr !== 7'd6 || bus.dout !== 8'h96) begin
            errors++;
            $display("FAIL abort_hold got addr=%h dout=%h want addr=06 dout=96",
                     bus.addr, bus.dout);
        end
    endtask

    task automatic test_wrap();
        clear_all();
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'($urandom));
        tx_q.push_back(8'($urandom));
        model_txn();
        run_txn(4);
        checks++;
        if (ev_q.size() != 2) begin
            errors++;
            $display("FAIL wrap_ev_count got %0d want 2", ev_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ev_q[i] !== exp_ev[i]) begin
                    errors++;
                    $display("FAIL wrap_ev[%0d] got %h want %h", i, ev_q[i], exp_ev[i]);
                end
            end
        end
        checks++;
        if (bus.addr !== 7'd1) begin
            errors++;
            $display("FAIL wrap_addr got %h want 01", bus.addr);
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        tx_q.push_back({7'($urandom), 1'b0});
        tx_q.push_back(8'($urandom));
        tx_q.push_back(8'($urandom));
        model_txn();
        run_txn(3);
        tx_q.delete();
        tx_q.push_back({7'($urandom), 1'b1});
        tx_q.push_back(8'($urandom));
        model_txn();
        run_txn(5);
        foreach (exp_rx[i]) begin
            checks++;
            if (rx_q[i] !== exp_rx[i]) begin
                errors++;
                $display("FAIL b2b_rx[%0d] got %h want %h", i, rx_q[i], exp_rx[i]);
            end
        end
        checks++;
        if (ev_q.size() != exp_ev.size()) begin
            errors++;
            $display("FAIL b2b_ev_count got %0d want %0d", ev_q.size(), exp_ev.size());
        end else begin
            foreach (exp_ev[i]) begin
                checks++;
                if (ev_q[i] !== exp_ev[i]) begin
                    errors++;
                    $display("FAIL b2b_ev[%0d] got %h want %h", i, ev_q[i], exp_ev[i]);
                end
            end
        end
        checks++;
        if (bus.addr !== exp_addr || bus.dout !== tx_q[1]) begin
            errors++;
            $display("FAIL b2b_final got addr=%h dout=%h want addr=%h dout=%h",
                     bus.addr, bus.dout, exp_addr, tx_q[1]);
        end
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 6; t++) begin
            clear_all();
            for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
            n = $urandom_range(1, 3);
            tx_q.push_back(8'($urandom));
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            model_txn();
            run_txn($urandom_range(3, 6));
            foreach (exp_rx[i]) begin
                checks++;
                if (rx_q[i] !== exp_rx[i]) begin
                    errors++;
                    $display("FAIL rand%0d_rx[%0d] got %h want %h", t, i, rx_q[i], exp_rx[i]);
                end
            end
            checks++;
            if (ev_q.size() != exp_ev.size()) begin
                errors++;
                $display("FAIL rand%0d_ev_count got %0d want %0d", t, ev_q.size(), exp_ev.size());
            end else begin
                foreach (exp_ev[i]) begin
                    checks++;
                    if (ev_q[i] !== exp_ev[i]) begin
                        errors++;
                        $display("FAIL rand%0d_ev[%0d] got %h want %h", t, i, ev_q[i], exp_ev[i]);
                    end
                end
            end
            checks++;
            if (bus.addr !== exp_addr) begin
                errors++;
                $display("FAIL rand%0d_addr got %h want %h", t, bus.addr, exp_addr);
            end
        end
        checks++;
        if (both_cnt != 0) begin
            errors++;
            $display("FAIL rd_we_overlap got %0d cycles want 0", both_cnt);
        end
    endtask

    initial begin
        rst     = 1'b1;
        bus.cs  = 1'b1;
        bus.sck = 1'b1;
        bus.si  = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        test_reset();
        test_read();
        test_write();
        test_abort();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
